atmega_uart_pump: RTL



---
 rtl/atmega_uart_pump.sv | 307 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/atmega_uart_pump.sv
// atmega_uart_pump: bus master that configures atmega_uart once, then polls UCSRA to move bytes between streams and UDR.
// Latency: config writes 1..4 cycles after enable seen in IDLE; TX push->UDR write 2 cycles; RXC seen->rx_valid 2 cycles.
// Backpressure: tx_ready = !tx_full; a full RX FIFO leaves UDR unread and sets sticky rx_ovf. RX path only with ATMEGA_UART_PUMP_RX_EN.
module atmega_uart_pump #(
  parameter int                           BUS_ADDR_DATA_LEN = 8,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] UDR_ADDR          = 'hc1,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] UCSRA_ADDR        = 'hc8,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] UCSRB_ADDR        = 'hc9,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] UCSRC_ADDR        = 'hca,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] UBRRL_ADDR        = 'hcc,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] UBRRH_ADDR        = 'hcd,
  parameter logic [7:0]                   UCSRC_VALUE       = 8'h06,
  parameter int                           TX_DEPTH_LOG2     = 4,
  parameter int                           RX_DEPTH_LOG2     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [11:0]                  baud_div,
  output logic [BUS_ADDR_DATA_LEN-1:0] m_addr,
  output logic                         m_wr,
  output logic                         m_rd,
  output logic [7:0]                   m_dout,
  input  logic [7:0]                   m_din,
  input  logic [7:0]                   tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic [7:0]                   rx_data,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic                         rx_ovf,
  input  logic                         ovf_clr,
  output logic                         cfg_done
);

  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;

  // UCSRB enable value: RXCIE must be set with RX, since the UART drops RXC while RXCIE=0.
`ifdef ATMEGA_UART_PUMP_RX_EN
  localparam logic [7:0] UCSRB_ON = 8'h98;
`else
  localparam logic [7:0] UCSRB_ON = 8'h08;
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG_H,
    S_CFG_L,
    S_CFG_C,
    S_CFG_B,
    S_POLL,
    S_RD,
    S_WR,
    S_SHUT
  } state_t;

  state_t                         state_q;
  logic [7:0]                     baud_lo_q;
  logic [BUS_ADDR_DATA_LEN-1:0]   m_addr_q;
  logic                           m_wr_q;
  logic                           m_rd_q;
  logic [7:0]                     m_dout_q;
  logic                           cfg_done_q;

  // UCSRA flags, meaningful only while the POLL read is on the bus
  logic poll_rxc;
  logic poll_udre;
  logic rx_full;

  assign poll_udre = m_din[5];

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]               tx_mem_q [TX_DEPTH];
  logic [TX_DEPTH_LOG2-1:0] tx_wr_ptr_q;
  logic [TX_DEPTH_LOG2-1:0] tx_rd_ptr_q;
  logic [TX_DEPTH_LOG2:0]   tx_cnt_q;
  logic [TX_DEPTH_LOG2:0]   tx_cnt_d;
  logic                     tx_full;
  logic                     tx_empty;
  logic                     tx_push;
  logic                     tx_pop;
  logic [7:0]               tx_head;

  // Count never exceeds the depth, so its MSB alone flags full.
  assign tx_full  = tx_cnt_q[TX_DEPTH_LOG2];
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && !tx_full;
  assign tx_pop   = (state_q == S_WR);
  assign tx_head  = tx_mem_q[tx_rd_ptr_q];

  // Occupancy after this cycle's push/pop
  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop) begin
      tx_cnt_d = tx_cnt_q + 1'b1;
    end else if (!tx_push && tx_pop) begin
      tx_cnt_d = tx_cnt_q - 1'b1;
    end
  end

  // TX storage: written on every accepted byte
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem_q[tx_wr_ptr_q] <= tx_data;
    end
  end

  // TX pointers and count
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
    end else begin
      if (tx_push) begin
        tx_wr_ptr_q <= tx_wr_ptr_q + 1'b1;
      end
      if (tx_pop) begin
        tx_rd_ptr_q <= tx_rd_ptr_q + 1'b1;
      end
      tx_cnt_q <= tx_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO (first-word fall-through) and overflow flag
  // ---------------------------------------------------------------------------
`ifdef ATMEGA_UART_PUMP_RX_EN
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;

  logic [7:0]               rx_mem_q [RX_DEPTH];
  logic [RX_DEPTH_LOG2-1:0] rx_wr_ptr_q;
  logic [RX_DEPTH_LOG2-1:0] rx_rd_ptr_q;
  logic [RX_DEPTH_LOG2:0]   rx_cnt_q;
  logic [RX_DEPTH_LOG2:0]   rx_cnt_d;
  logic                     rx_empty;
  logic                     rx_push;
  logic                     rx_pop;
  logic                     ovf_set;
  logic                     rx_ovf_q;

  assign poll_rxc = m_din[7];
  assign rx_full  = rx_cnt_q[RX_DEPTH_LOG2];
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_push  = (state_q == S_RD);
  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;
  // Head is masked while empty so rx_data reads 0 out of reset.
  assign rx_data  = rx_empty ? 8'h00 : rx_mem_q[rx_rd_ptr_q];
  // Overflow only counts when POLL actually branches on RXC (enable still high).
  assign ovf_set  = (state_q == S_POLL) && enable && poll_rxc && rx_full;
  assign rx_ovf   = rx_ovf_q;

  // Occupancy after this cycle's push/pop
  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop) begin
      rx_cnt_d = rx_cnt_q + 1'b1;
    end else if (!rx_push && rx_pop) begin
      rx_cnt_d = rx_cnt_q - 1'b1;
    end
  end

  // RX storage: UDR value captured during the RD access
  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem_q[rx_wr_ptr_q] <= m_din;
    end
  end

  // RX pointers, count and sticky overflow (set beats clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      rx_ovf_q    <= 1'b0;
    end else begin
      if (rx_push) begin
        rx_wr_ptr_q <= rx_wr_ptr_q + 1'b1;
      end
      if (rx_pop) begin
        rx_rd_ptr_q <= rx_rd_ptr_q + 1'b1;
      end
      rx_cnt_q <= rx_cnt_d;
      if (ovf_set) begin
        rx_ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        rx_ovf_q <= 1'b0;
      end
    end
  end
`else
  logic unused_rx_inputs;

  assign poll_rxc         = 1'b0;
  assign rx_full          = 1'b0;
  assign rx_valid         = 1'b0;
  assign rx_data          = 8'h00;
  assign rx_ovf           = 1'b0;
  assign unused_rx_inputs = ^{rx_ready, ovf_clr, m_din, RX_DEPTH_LOG2};
`endif

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  // State, bus signals and cfg_done are registered for the state being entered,
  // so each access is on the bus for exactly the cycle its state is current.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_lo_q  <= '0;
      m_addr_q   <= '0;
      m_wr_q     <= 1'b0;
      m_rd_q     <= 1'b0;
      m_dout_q   <= '0;
      cfg_done_q <= 1'b0;
    end else begin
      m_addr_q   <= '0;
      m_wr_q     <= 1'b0;
      m_rd_q     <= 1'b0;
      m_dout_q   <= '0;
      cfg_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            baud_lo_q <= baud_div[7:0];
            state_q   <= S_CFG_H;
            m_wr_q    <= 1'b1;
            m_addr_q  <= UBRRH_ADDR;
            m_dout_q  <= {4'h0, baud_div[11:8]};
          end
        end
        S_CFG_H: begin
          state_q  <= S_CFG_L;
          m_wr_q   <= 1'b1;
          m_addr_q <= UBRRL_ADDR;
          m_dout_q <= baud_lo_q;
        end
        S_CFG_L: begin
          state_q  <= S_CFG_C;
          m_wr_q   <= 1'b1;
          m_addr_q <= UCSRC_ADDR;
          m_dout_q <= UCSRC_VALUE;
        end
        S_CFG_C: begin
          state_q  <= S_CFG_B;
          m_wr_q   <= 1'b1;
          m_addr_q <= UCSRB_ADDR;
          m_dout_q <= UCSRB_ON;
        end
        S_CFG_B, S_RD, S_WR: begin
          state_q    <= S_POLL;
          m_rd_q     <= 1'b1;
          m_addr_q   <= UCSRA_ADDR;
          cfg_done_q <= 1'b1;
        end
        S_POLL: begin
          if (!enable) begin
            state_q  <= S_SHUT;
            m_wr_q   <= 1'b1;
            m_addr_q <= UCSRB_ADDR;
            m_dout_q <= 8'h00;
          end else if (poll_rxc && !rx_full) begin
            state_q    <= S_RD;
            m_rd_q     <= 1'b1;
            m_addr_q   <= UDR_ADDR;
            cfg_done_q <= 1'b1;
          end else if (poll_rxc) begin
            // UART holds a byte we cannot take: leave it in UDR and keep polling
            state_q    <= S_POLL;
            m_rd_q     <= 1'b1;
            m_addr_q   <= UCSRA_ADDR;
            cfg_done_q <= 1'b1;
          end else if (poll_udre && !tx_empty) begin
            state_q    <= S_WR;
            m_wr_q     <= 1'b1;
            m_addr_q   <= UDR_ADDR;
            m_dout_q   <= tx_head;
            cfg_done_q <= 1'b1;
          end else begin
            state_q    <= S_POLL;
            m_rd_q     <= 1'b1;
            m_addr_q   <= UCSRA_ADDR;
            cfg_done_q <= 1'b1;
          end
        end
        S_SHUT: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign m_addr   = m_addr_q;
  assign m_wr     = m_wr_q;
  assign m_rd     = m_rd_q;
  assign m_dout   = m_dout_q;
  assign cfg_done = cfg_done_q;

endmodule
